// File: rtl/usb_fifo_arbiter.sv
// Synchronous 245-style USB FIFO bus controller: drives the read/write strobes and bus turnaround,
// and round-robin arbitrates host->FPGA reads against FPGA->host writes with bounded bursts.
module usb_fifo_arbiter #(
  parameter  int FIFO_BUS_WIDTH = 4,
  parameter  int MAX_BURST      = 64,
  parameter  int CNT_WIDTH      = 32,
  localparam int DW             = FIFO_BUS_WIDTH * 8
) (
  input  logic                 usb_clk,
  input  logic                 rst_glbl,
  input  logic                 usb_rxf_n,
  input  logic                 usb_txe_n,
  input  logic [DW-1:0]        usb_data_i,
  output logic [DW-1:0]        usb_data_o,
  output logic                 usb_data_oe,
  output logic                 usb_oe_n,
  output logic                 usb_rd_n,
  output logic                 usb_wr_n,
  output logic [DW-1:0]        rx_data,
  output logic                 rx_valid,
  input  logic                 rx_afull,
  input  logic [DW-1:0]        tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] rx_word_cnt,
  output logic [CNT_WIDTH-1:0] tx_word_cnt
);

  localparam int            BW        = 17;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, RD_OE, RD, WR, TURN} state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  state_t        state, state_nxt;
  grant_t        last_grant, last_grant_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          out_vld, out_vld_nxt;

  logic req_rd, req_wr, rd_xfer, accept, tx_load;

  assign req_rd   = !usb_rxf_n && !rx_afull;
  assign req_wr   = !usb_txe_n && tx_valid;
  assign rd_xfer  = (state == RD) && !usb_rd_n && !usb_rxf_n;
  assign accept   = (state == WR) && !usb_wr_n && !usb_txe_n;
  // A new word may be taken when the output slot is free or is being drained this edge,
  // and only while the burst still has room for it.
  assign tx_ready = (state == WR) && (!out_vld || accept) &&
                    ((burst_cnt + BW'(out_vld)) < BURST_MAX);
  assign tx_load  = tx_valid && tx_ready;

  // NOTE: every signal written here gets a default first, so no path through the case leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    burst_nxt      = burst_cnt;
    out_vld_nxt    = out_vld;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (req_rd && (!req_wr || last_grant == GRANT_WR)) begin
          state_nxt      = RD_OE;
          burst_nxt      = '0;
          last_grant_nxt = GRANT_RD;
        end else if (req_wr) begin
          state_nxt      = WR;
          burst_nxt      = '0;
          last_grant_nxt = GRANT_WR;
        end
      end
      RD_OE: state_nxt = RD;
      RD: begin
        burst_nxt = burst_cnt + BW'(rd_xfer);
        if (usb_rxf_n || rx_afull || burst_nxt >= BURST_MAX) state_nxt = TURN;
      end
      WR: begin
        burst_nxt   = burst_cnt + BW'(accept);
        out_vld_nxt = tx_load || (out_vld && !accept);
        if (!out_vld_nxt && (!tx_valid || usb_txe_n || burst_nxt >= BURST_MAX))
          state_nxt = TURN;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge usb_clk) begin
    if (rst_glbl) begin
      state       <= IDLE;
      last_grant  <= GRANT_WR;
      burst_cnt   <= '0;
      out_vld     <= 1'b0;
      usb_oe_n    <= 1'b1;
      usb_rd_n    <= 1'b1;
      usb_wr_n    <= 1'b1;
      usb_data_oe <= 1'b0;
      usb_data_o  <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      rx_word_cnt <= '0;
      tx_word_cnt <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      burst_cnt   <= burst_nxt;
      out_vld     <= out_vld_nxt;
      // Strobes are decoded from the next state so TURN always separates driving directions.
      usb_oe_n    <= !(state_nxt == RD_OE || state_nxt == RD);
      usb_rd_n    <= !(state_nxt == RD);
      usb_data_oe <= (state_nxt == WR);
      usb_wr_n    <= !out_vld_nxt;
      busy        <= (state_nxt != IDLE);
      rx_valid    <= rd_xfer;
      if (tx_load) usb_data_o <= tx_data;
      if (rd_xfer) begin
        rx_data     <= usb_data_i;
        rx_word_cnt <= rx_word_cnt + CNT_WIDTH'(1);
      end
      if (accept) tx_word_cnt <= tx_word_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Bench for usb_fifo_arbiter: a PHY/stream model advanced once per cycle by tick(), a table of
// single-edge arbitration vectors, and hand-written burst, stall, almost-full and reset sequences.
module tb_usb_fifo_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_glbl = 1'b1;
  logic          usb_rxf_n = 1'b1, usb_txe_n = 1'b1;
  logic [DW-1:0] usb_data_i = '0, tx_data = '0;
  logic          tx_valid = 1'b0, rx_afull = 1'b0;

  logic [DW-1:0] usb_data_o, rx_data;
  logic          usb_data_oe, usb_oe_n, usb_rd_n, usb_wr_n, rx_valid, tx_ready, busy;
  logic [31:0]   rx_word_cnt, tx_word_cnt;

  logic [DW-1:0] w_data_o, w_rx_data;
  logic          w_data_oe, w_oe_n, w_rd_n, w_wr_n, w_rx_valid, w_tx_ready, w_busy;
  logic [3:0]    w_rx_word_cnt, w_tx_word_cnt;

  usb_fifo_arbiter #(.FIFO_BUS_WIDTH(4), .MAX_BURST(4), .CNT_WIDTH(32)) u_dut (
    .usb_clk(clk), .rst_glbl(rst_glbl), .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n),
    .usb_data_i(usb_data_i), .usb_data_o(usb_data_o), .usb_data_oe(usb_data_oe),
    .usb_oe_n(usb_oe_n), .usb_rd_n(usb_rd_n), .usb_wr_n(usb_wr_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_afull(rx_afull), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .rx_word_cnt(rx_word_cnt), .tx_word_cnt(tx_word_cnt)
  );

  // Same stimulus, 4-bit counters: observes wrap-around after a handful of words.
  usb_fifo_arbiter #(.FIFO_BUS_WIDTH(4), .MAX_BURST(4), .CNT_WIDTH(4)) u_wrap (
    .usb_clk(clk), .rst_glbl(rst_glbl), .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n),
    .usb_data_i(usb_data_i), .usb_data_o(w_data_o), .usb_data_oe(w_data_oe),
    .usb_oe_n(w_oe_n), .usb_rd_n(w_rd_n), .usb_wr_n(w_wr_n), .rx_data(w_rx_data),
    .rx_valid(w_rx_valid), .rx_afull(rx_afull), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(w_tx_ready), .busy(w_busy), .rx_word_cnt(w_rx_word_cnt),
    .tx_word_cnt(w_tx_word_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] rx_q[$], tx_src[$], rx_got[$], tx_got[$];
  int            pass_cnt = 0, total_cnt = 0;
  int            conflicts = 0, wr_low = 0, rd_low = 0;
  bit            log_en = 1'b0;
  string         trace = "";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
  endtask

  function automatic byte phase();
    if (!busy)                                            return "I";
    if (!usb_oe_n && usb_rd_n && !usb_data_oe)            return "O";
    if (!usb_oe_n && !usb_rd_n)                           return "R";
    if (usb_data_oe && usb_oe_n)                          return "W";
    if (usb_oe_n && usb_rd_n && usb_wr_n && !usb_data_oe) return "T";
    return "X";
  endfunction

  function automatic string compress(input string s);
    string r = "";
    byte   prev = 0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] != prev) begin
        r    = $sformatf("%s%c", r, s[i]);
        prev = s[i];
      end
    return r;
  endfunction

  function automatic int long_runs(input string s, input byte c);
    int n = 0;
    for (int i = 1; i < s.len(); i++) if (s[i] == c && s[i-1] == c) n++;
    return n;
  endfunction

  function automatic int seq_errs(input logic [DW-1:0] q[$], input logic [DW-1:0] base,
                                  input int n);
    int e = (q.size() != n) ? 1 : 0;
    for (int i = 0; i < n; i++) if (i >= q.size() || q[i] !== base + DW'(i)) e++;
    return e;
  endfunction

  function automatic logic [5:0] strobes();
    return {busy, usb_oe_n, usb_rd_n, usb_wr_n, usb_data_oe, tx_ready};
  endfunction

  // One clock cycle of the PHY and TX-source model; returns at the following falling edge.
  task automatic tick();
    logic          rd_fire, wr_fire, tx_hs, rv;
    logic [DW-1:0] wd, rdat;
    @(posedge clk);
    rd_fire = !usb_rd_n && !usb_rxf_n;
    wr_fire = !usb_wr_n && !usb_txe_n;
    tx_hs   = tx_valid && tx_ready;
    wd      = usb_data_o;
    rv      = rx_valid;
    rdat    = rx_data;
    #1;
    if (rd_fire && rx_q.size() != 0) void'(rx_q.pop_front());
    if (wr_fire) tx_got.push_back(wd);
    if (tx_hs && tx_src.size() != 0) void'(tx_src.pop_front());
    if (rv) rx_got.push_back(rdat);
    usb_rxf_n  = (rx_q.size() == 0);
    usb_data_i = (rx_q.size() != 0) ? rx_q[0] : '0;
    tx_valid   = (tx_src.size() != 0);
    tx_data    = (tx_src.size() != 0) ? tx_src[0] : '0;
    @(negedge clk);
    if (usb_data_oe && !usb_oe_n) conflicts++;
    if (log_en) begin
      trace = $sformatf("%s%c", trace, phase());
      if (!usb_wr_n) wr_low++;
      if (!usb_rd_n) rd_low++;
    end
  endtask

  typedef struct {
    string      name;
    bit         rx_word;
    bit         tx_word;
    bit         txe_n;
    bit         afull;
    logic [5:0] exp;  // {busy, oe_n, rd_n, wr_n, data_oe, tx_ready} one edge after reset
  } vec_t;

  vec_t vecs[8];
  int   pulses;

  initial begin
    vecs[0] = '{"arb_none",        1'b0, 1'b0, 1'b1, 1'b0, 6'b011100};
    vecs[1] = '{"arb_rd_only",     1'b1, 1'b0, 1'b1, 1'b0, 6'b101100};
    vecs[2] = '{"arb_rd_afull",    1'b1, 1'b0, 1'b1, 1'b1, 6'b011100};
    vecs[3] = '{"arb_wr_only",     1'b0, 1'b1, 1'b0, 1'b0, 6'b111111};
    vecs[4] = '{"arb_wr_no_valid", 1'b0, 1'b0, 1'b0, 1'b0, 6'b011100};
    vecs[5] = '{"arb_wr_txe_high", 1'b0, 1'b1, 1'b1, 1'b0, 6'b011100};
    vecs[6] = '{"arb_both_to_rd",  1'b1, 1'b1, 1'b0, 1'b0, 6'b101100};
    vecs[7] = '{"arb_afull_to_wr", 1'b1, 1'b1, 1'b0, 1'b1, 6'b111111};

    tick(); tick();
    rst_glbl = 1'b0;
    tick();
    check("reset_strobes", 32'(strobes()), 32'h1C);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_data", usb_data_o | rx_data, 32'h0);
    check("reset_counts", rx_word_cnt | tx_word_cnt, 32'h0);

    foreach (vecs[i]) begin
      rst_glbl = 1'b1;
      rx_q.delete(); tx_src.delete();
      if (vecs[i].rx_word) rx_q.push_back(32'h5A);
      if (vecs[i].tx_word) tx_src.push_back(32'h77);
      usb_txe_n = vecs[i].txe_n;
      rx_afull  = vecs[i].afull;
      tick();
      rst_glbl = 1'b0;
      tick();
      check(vecs[i].name, 32'(strobes()), 32'(vecs[i].exp));
    end
    rst_glbl = 1'b1;
    rx_q.delete(); tx_src.delete();
    usb_txe_n = 1'b1; rx_afull = 1'b0;
    tick(); tick();
    rst_glbl = 1'b0;
    tick();
    rx_got.delete(); tx_got.delete();

    // Read burst of five words: four hit the burst limit, the fifth is a second grant.
    trace = ""; log_en = 1'b1;
    for (int i = 0; i < 5; i++) rx_q.push_back(32'h11 + i);
    for (int i = 0; i < 200 && !(rx_got.size() == 5 && !busy); i++) tick();
    tick(); tick();
    log_en = 1'b0;
    check_str("s1_trace", compress(trace), "IORTIORTI");
    check("s1_single_oe_turn", 32'(long_runs(trace, "O") + long_runs(trace, "T")), 32'h0);
    check("s1_rx_words", 32'(seq_errs(rx_got, 32'h11, 5)), 32'h0);
    check("s1_rx_cnt", rx_word_cnt, 32'd5);

    // Write three words.
    trace = ""; wr_low = 0; log_en = 1'b1; tx_got.delete();
    usb_txe_n = 1'b0;
    for (int i = 0; i < 3; i++) tx_src.push_back(32'hA0 + i);
    for (int i = 0; i < 200 && !(tx_got.size() == 3 && !busy); i++) tick();
    tick();
    log_en = 1'b0;
    check_str("s2_trace", compress(trace), "IWTI");
    check("s2_wr_low_cycles", 32'(wr_low), 32'd3);
    check("s2_tx_words", 32'(seq_errs(tx_got, 32'hA0, 3)), 32'h0);
    check("s2_tx_cnt", tx_word_cnt, 32'd3);

    // Both directions pending: grants alternate, four words each.
    trace = ""; log_en = 1'b1; rx_got.delete(); tx_got.delete();
    for (int i = 0; i < 8; i++) begin
      rx_q.push_back(32'h20 + i);
      tx_src.push_back(32'hB0 + i);
    end
    for (int i = 0; i < 400 && !(rx_got.size() == 8 && tx_got.size() == 8 && !busy); i++) tick();
    tick();
    log_en = 1'b0;
    check_str("s3_trace", compress(trace), "IORTIWTIORTIWTI");
    check("s3_rx_words", 32'(seq_errs(rx_got, 32'h20, 8)), 32'h0);
    check("s3_tx_words", 32'(seq_errs(tx_got, 32'hB0, 8)), 32'h0);
    check("s3_counts", {rx_word_cnt[15:0], tx_word_cnt[15:0]}, {16'd13, 16'd11});

    // PHY stops accepting mid-burst for ten cycles.
    tx_got.delete(); wr_low = 0;
    for (int i = 0; i < 4; i++) tx_src.push_back(32'hC0 + i);
    for (int i = 0; i < 200 && tx_got.size() < 1; i++) tick();
    usb_txe_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (usb_wr_n !== 1'b0 || usb_data_o !== 32'hC1 || tx_ready !== 1'b0 || busy !== 1'b1)
        pulses++;
    end
    check("s4_hold_during_stall", 32'(pulses), 32'h0);
    usb_txe_n = 1'b0;
    for (int i = 0; i < 200 && !(tx_got.size() == 4 && !busy); i++) tick();
    check("s4_tx_words", 32'(seq_errs(tx_got, 32'hC0, 4)), 32'h0);
    check("s4_tx_cnt", tx_word_cnt, 32'd15);

    // Sink almost-full during a read burst.
    rx_got.delete();
    for (int i = 0; i < 6; i++) rx_q.push_back(32'h30 + i);
    for (int i = 0; i < 200 && rx_got.size() < 1; i++) tick();
    rx_afull = 1'b1;
    pulses = rx_got.size();
    tick();
    check("s5_rd_n_high", 32'(usb_rd_n), 32'h1);
    rd_low = 0; log_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    log_en = 1'b0;
    check("s5_no_read_while_afull", 32'(rd_low), 32'h0);
    pulses = rx_got.size() - pulses;
    check("s5_pulses_after_rise_le2", 32'(pulses <= 2), 32'h1);
    rx_afull = 1'b0;
    for (int i = 0; i < 200 && !(rx_got.size() == 6 && !busy); i++) tick();
    check("s5_rx_words", 32'(seq_errs(rx_got, 32'h30, 6)), 32'h0);
    check("s5_rx_cnt", rx_word_cnt, 32'd19);
    check("wrap_rx_cnt4", 32'(w_rx_word_cnt), 32'd3);
    check("wrap_tx_cnt4_at_15", 32'(w_tx_word_cnt), 32'd15);

    // One more write takes the narrow counter across the wrap, then reset lands mid-WR.
    tx_got.delete();
    for (int i = 0; i < 6; i++) tx_src.push_back(32'hD0 + i);
    for (int i = 0; i < 200 && tx_got.size() < 1; i++) tick();
    check("s6_tx_cnt", tx_word_cnt, 32'd16);
    check("wrap_tx_cnt4_to_0", 32'(w_tx_word_cnt), 32'd0);
    check("s6_in_wr_before_reset", {24'h0, phase()}, 32'h57);
    rst_glbl = 1'b1;
    tick();
    check("s6_reset_strobes", 32'(strobes()), 32'h1C);
    check("s6_reset_data_o", usb_data_o, 32'h0);
    check("s6_reset_counts", rx_word_cnt | tx_word_cnt | 32'(w_rx_word_cnt), 32'h0);
    tx_src.delete();
    tick();
    rst_glbl = 1'b0;
    tick(); tick();

    check("bus_contention_cycles", 32'(conflicts), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/usb_fifo_arbiter.md
Name: usb_fifo_arbiter

Overview:
- Controller for the synchronous 245-style USB FIFO bus on usb_clk; shares the half-duplex data bus between host-to-FPGA reads (RX) and FPGA-to-host writes (TX).
- Runs all bus strobes and bus turnaround, and round-robin arbitrates between the two directions with bounded bursts.
- Faces the USB PHY FIFO pins on one side; faces the local RX sink (FIFO with almost-full) and TX source (valid/ready stream) on the other.

Parameters:
- FIFO_BUS_WIDTH, 4, USB data bus width in bytes; data width DW = FIFO_BUS_WIDTH*8.
- MAX_BURST, 64, maximum words per grant (1..65535).
- CNT_WIDTH, 32, width of the transfer word counters.

Ports:
- usb_clk  in  1  USB FIFO clock; the only clock.
- rst_glbl  in  1  synchronous, active-high reset.
- usb_rxf_n  in  1  low = PHY holds read data.
- usb_txe_n  in  1  low = PHY can accept write data.
- usb_data_i  in  DW  bus input.
- usb_data_o  out  DW  bus output.
- usb_data_oe  out  1  1 = FPGA drives bus.
- usb_oe_n  out  1  PHY output enable, active low.
- usb_rd_n  out  1  read strobe, active low.
- usb_wr_n  out  1  write strobe, active low.
- rx_data  out  DW  received word.
- rx_valid  out  1  one-cycle pulse per received word; no backpressure.
- rx_afull  in  1  sink almost full; sink must keep at least 2 words of slack.
- tx_data  in  DW  word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  word taken on tx_valid & tx_ready.
- busy  out  1  state != IDLE.
- rx_word_cnt  out  CNT_WIDTH  total words read; wraps.
- tx_word_cnt  out  CNT_WIDTH  total words written; wraps.

Behaviour:
- Registers and state: all outputs registered. States are IDLE, RD_OE, RD, WR, TURN. Burst counter burst_cnt. Pending flag out_vld for the output word. last_grant.
- Reset values: state IDLE; usb_oe_n, usb_rd_n, usb_wr_n = 1; usb_data_oe = 0; usb_data_o = 0; rx_data = 0; rx_valid = 0; tx_ready = 0; busy = 0; counters = 0; out_vld = 0; last_grant = WR, so the first contention goes to read.
- Mid-operation reset: returns to the reset state on the next edge. A pending TX word is dropped.
- Requests, sampled in IDLE: req_rd = !usb_rxf_n & !rx_afull. req_wr = !usb_txe_n & tx_valid.
  - Only one request: grant it.
  - Both requests: grant the direction opposite to last_grant.
  - Neither: stay in IDLE.
  - burst_cnt is cleared on every grant.
- Read path:
  - IDLE -> RD_OE: one cycle with usb_oe_n = 0, usb_rd_n = 1, usb_data_oe = 0.
  - RD_OE -> RD: usb_oe_n = 0 and usb_rd_n = 0 in every RD cycle.
  - A read transfer happens on each edge where usb_rd_n = 0 and usb_rxf_n = 0. On that edge: rx_data <= usb_data_i, rx_valid = 1 in the following cycle, rx_word_cnt + 1, burst_cnt + 1.
  - RD -> TURN on the edge where usb_rxf_n = 1, or rx_afull = 1, or burst_cnt + transfer reaches MAX_BURST. A transfer on that same edge still counts.
- Write path:
  - IDLE -> WR: usb_data_oe = 1 and usb_oe_n = 1 throughout WR.
  - tx_ready = WR & (!out_vld | accept) & (burst_cnt + out_vld < MAX_BURST), where accept = !usb_wr_n & !usb_txe_n.
  - On a tx handshake: usb_data_o <= tx_data, out_vld = 1, usb_wr_n = 0 from the next cycle.
  - On accept: tx_word_cnt + 1, burst_cnt + 1; out_vld clears unless a new word is loaded on the same edge.
  - While usb_txe_n = 1 and out_vld = 1: word and usb_wr_n = 0 are held.
  - WR -> TURN when out_vld = 0 after the edge and (tx_valid = 0, or usb_txe_n = 1, or burst_cnt = MAX_BURST).
- TURN: exactly one cycle with all strobes = 1 and usb_data_oe = 0. Then IDLE, with last_grant updated. There is no bus contention: usb_data_oe = 1 never overlaps usb_oe_n = 0.
- Counters: wrap modulo 2^CNT_WIDTH with no saturation.

Test Plan:
- Reset, then usb_rxf_n low with 5 words 0x11..0x15 and rx_afull low -> RD_OE 1 cycle, then RD. Exactly 5 rx_valid pulses carry 0x11..0x15 in order. rx_word_cnt = 5. Ends with TURN then IDLE.
- tx_valid with 3 words 0xA0..0xA2, usb_txe_n low -> usb_wr_n low for 3 cycles with data A0, A1, A2. tx_word_cnt = 3. usb_data_oe falls in TURN.
- Both requests pending continuously, MAX_BURST = 4 -> grants alternate RD, WR, RD, WR. Each burst is 4 words. A TURN cycle separates every grant.
- usb_txe_n forced high for 10 cycles mid-burst -> pending word and usb_wr_n = 0 are held. tx_ready = 0. No word is lost or duplicated after usb_txe_n returns low.
- rx_afull raised during RD -> usb_rd_n high within 1 cycle of the sampled edge. At most 2 rx_valid pulses after the rise. Read resumes after rx_afull falls.
- rst_glbl asserted during WR, and rx_word_cnt preloaded near wrap -> next edge gives IDLE with all strobes high and usb_data_oe = 0. In a separate run, the counter wraps 0xFFFFFFFF -> 0.
